// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter
// Brief    : 4-way round-robin arbiter with a registered grant and an owner
//            data mux. Optional burst limit: define RR_ARB_BURST_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter #(
  parameter int W         = 1,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  output logic [3:0]   gnt,
  output logic         s1,
  output logic         s0,
  output logic         valid,
  output logic [W-1:0] f
);

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_GRANT = 1'b1;

  logic [0:0] r_state;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic       r_valid;
  logic [1:0] r_ptr;

  logic       w_keep;
  logic [3:0] w_cand;
  logic       w_found;
  logic [1:0] w_win;
  logic [1:0] w_idx;

`ifdef RR_ARB_BURST_LIMIT_EN
  localparam int c_CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_BURST - 1);

  logic [c_CNT_W-1:0] r_burst_cnt;
  logic               w_burst_done;

  // Counter holds (cycles owned - 1); the last owned cycle forces a rotation.
  assign w_burst_done = (r_burst_cnt >= c_CNT_LAST);
  assign w_keep       = req[r_sel] && !w_burst_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_burst_cnt <= '0;
    end else if (r_state == c_GRANT && w_keep) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
    end else begin
      r_burst_cnt <= '0;
    end
  end
`else
  assign w_keep = req[r_sel];

  // MAX_BURST only matters when the burst limit is compiled in.
  if (MAX_BURST < 1) begin : g_max_burst_unused
  end
`endif

  // While granted, the current owner is excluded from the next arbitration.
  always_comb begin
    w_cand = req;
    if (r_state == c_GRANT) begin
      w_cand = req & ~(4'b0001 << r_sel);
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
      r_ptr   <= 2'd3;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found) begin
            r_state <= c_GRANT;
            r_gnt   <= 4'b0001 << w_win;
            r_sel   <= w_win;
            r_valid <= 1'b1;
            r_ptr   <= w_win;
          end
        end
        c_GRANT: begin
          if (!w_keep) begin
            if (w_found) begin
              r_gnt   <= 4'b0001 << w_win;
              r_sel   <= w_win;
              r_ptr   <= w_win;
            end else begin
              // Select lines keep the last owner while idle.
              r_state <= c_IDLE;
              r_gnt   <= 4'b0000;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_gnt   <= 4'b0000;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign s1    = r_sel[1];
  assign s0    = r_sel[0];
  assign valid = r_valid;

  always_comb begin
    f = '0;
    if (r_valid) begin
      case (r_sel)
        2'd0:    f = x0;
        2'd1:    f = x1;
        2'd2:    f = x2;
        default: f = x3;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arbiter
// Brief    : Scoreboard bench for rr_mux_arbiter against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

  localparam int W         = 8;
  localparam int MAX_BURST = 4;
`ifdef RR_ARB_BURST_LIMIT_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req   = 4'b0000;
  logic [W-1:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
  logic [3:0]   gnt;
  logic         s1, s0, valid;
  logic [W-1:0] f;

  rr_mux_arbiter #(.W(W), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .x0    (x0),
    .x1    (x1),
    .x2    (x2),
    .x3    (x3),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .valid (valid),
    .f     (f)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         valid;
    logic [W-1:0] f;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: owner index (-1 = none), last winner, last select, cycles held.
  int m_owner = -1;
  int m_ptr   = 3;
  int m_sel   = 0;
  int m_held  = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int rr_pick(logic [3:0] r, int ptr);
    for (int k = 1; k <= 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 3;
    m_sel   = 0;
    m_held  = 0;
  endtask

  task automatic model_step(logic [3:0] r);
    logic [3:0]   others;
    logic [W-1:0] xv[4];
    exp_t         e;
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        m_owner = rr_pick(r, m_ptr);
        m_ptr   = m_owner;
        m_sel   = m_owner;
        m_held  = 1;
      end
    end else if (r[m_owner] && !(BURST_EN && m_held >= MAX_BURST)) begin
      m_held++;
    end else begin
      others = r & ~(4'b0001 << m_owner);
      if (others != 4'b0000) begin
        m_owner = rr_pick(others, m_ptr);
        m_ptr   = m_owner;
        m_sel   = m_owner;
        m_held  = 1;
      end else begin
        m_owner = -1;
      end
    end
    xv      = '{x0, x1, x2, x3};
    e.valid = (m_owner >= 0);
    e.sel   = 2'(m_sel);
    e.gnt   = e.valid ? (4'b0001 << m_sel) : 4'b0000;
    e.f     = e.valid ? xv[m_sel] : '0;
    exp_q.push_back(e);
  endtask

  task automatic apply(logic [3:0] r);
    req = r;
    x0  = W'($urandom);
    x1  = W'($urandom);
    x2  = W'($urandom);
    x3  = W'($urandom);
    model_step(r);
  endtask

  task automatic drive(logic [3:0] r);
    @(negedge clk);
    apply(r);
  endtask

  // Monitor: outputs settle after each rising edge and stay until the next edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",   32'(gnt),      32'(e.gnt));
        check("sel",   32'({s1, s0}), 32'(e.sel));
        check("valid", 32'(valid),    32'(e.valid));
        check("f",     32'(f),        32'(e.f));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r_rand;
    x0 = 8'h11; x1 = 8'h22; x2 = 8'h33; x3 = 8'h44;
    req = 4'b1111;
    @(negedge clk);
    check("reset_gnt",   32'(gnt),      32'h0);
    check("reset_sel",   32'({s1, s0}), 32'h0);
    check("reset_valid", 32'(valid),    32'h0);
    check("reset_f",     32'(f),        32'h0);

    // Release with all requesting: requester 0 must win first.
    @(negedge clk);
    reset = 1'b0;
    apply(4'b1111);
    drive(4'b1111);
    drive(4'b1110);
    drive(4'b1100);
    drive(4'b1000);
    drive(4'b1000);
    drive(4'b0000);

    repeat (10) drive(4'b0100);
    repeat (3)  drive(4'b0000);
    repeat (12) drive(4'b0011);
    drive(4'b0000);

    r_rand = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) r_rand = 4'($urandom_range(0, 15));
      drive(r_rand);
    end

    // Asynchronous reset between edges while a grant is active.
    repeat (3) drive(4'b0010);
    @(posedge clk);
    #3;
    check("pre_reset_valid", 32'(valid), 32'(m_owner >= 0));
    reset = 1'b1;
    #1;
    check("async_gnt",   32'(gnt),      32'h0);
    check("async_sel",   32'({s1, s0}), 32'h0);
    check("async_valid", 32'(valid),    32'h0);
    check("async_f",     32'(f),        32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    apply(4'b1111);
    for (int n = 0; n < 30; n++) drive(4'($urandom_range(0, 15)));
    drive(4'b0000);

    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
- REQ-001 The block SHALL have parameter W, default 1, setting the width of each data input and of the output.
- REQ-002 The block SHALL have parameter MAX_BURST, default 4, setting the grant cycle limit; it is used only when the burst limit is compiled in (REQ-021).
- REQ-003 The clock port SHALL be `clk`, input, 1 bit; every register SHALL update on its rising edge.
- REQ-004 The reset port SHALL be `reset`, input, 1 bit; reset is asynchronous and active-high.
- REQ-005 The request port SHALL be `req`, input, 4 bits; bit i is the request from requester i.
- REQ-006 The data inputs SHALL be `x0`, `x1`, `x2`, `x3`, input, W bits each; xi is the data of requester i.
- REQ-007 The grant port SHALL be `gnt`, output, 4 bits, one-hot or zero, registered.
- REQ-008 The select ports SHALL be `s1` and `s0`, output, 1 bit each, registered; they form the encoded index of the owner.
- REQ-009 The `valid` port SHALL be output, 1 bit, registered, high while any grant is active.
- REQ-010 The `f` port SHALL be output, W bits: the data of the owner, or 0 when `valid`=0.

Function
- REQ-011 The state machine SHALL have two states, IDLE and GRANT.
- REQ-012 In IDLE, if req != 0, the block SHALL enter GRANT on the next edge and register the arbitration winner into `gnt`, `{s1,s0}` and `valid`=1. Latency from req to gnt is 1 cycle.
- REQ-013 Arbitration SHALL be round-robin: search the indices in the order ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is the index of the last owner; the first asserted request wins.
- REQ-014 ptr SHALL update to the winner index on every new grant.
- REQ-015 In GRANT, while req[owner]=1, `gnt`, `{s1,s0}` and `valid` SHALL hold unchanged.
- REQ-016 In GRANT, when req[owner]=0 is sampled and another request is pending, the next edge SHALL grant the round-robin winner among the other requests, with no idle bubble.
- REQ-017 In GRANT, when req[owner]=0 is sampled and no other request is pending, the next edge SHALL return to IDLE with gnt=0 and valid=0. `{s1,s0}` SHALL hold its last value.
- REQ-018 `f` SHALL be combinational from `{s1,s0}`, `valid` and x0..x3, and SHALL select x0, x1, x2 or x3 for `{s1,s0}` = 00, 01, 10 or 11.
- REQ-019 `gnt` SHALL always equal the one-hot decode of `{s1,s0}` when valid=1, and 0 when valid=0.
- REQ-020 Simultaneous requests SHALL be resolved by REQ-013 only, with no fixed priority except from reset.

Configuration
- REQ-021 With the macro RR_ARB_BURST_LIMIT_EN defined, a burst counter SHALL count owner cycles.
  - After MAX_BURST consecutive cycles with valid=1 for the same owner, the grant SHALL be forcibly rotated as in REQ-016/REQ-017, treating req[owner] as 0 for that one arbitration.
  - The counter SHALL reset to 0 on every new grant and in IDLE.
- REQ-022 With RR_ARB_BURST_LIMIT_EN not defined, there SHALL be no counter; a grant lasts until the owner's request drops.

Reset
- REQ-023 While reset=1, the block SHALL force: state=IDLE, gnt=0, s1=0, s0=0, valid=0, ptr=3, burst counter=0.
  - With these values f=0, and requester 0 has first priority after reset.
- REQ-024 Assertion of reset SHALL clear the outputs immediately, without waiting for clk, including mid-grant.
- REQ-025 The first edge after reset deasserts SHALL arbitrate normally.

Verification
- REQ-026 Reset release with req=4'b1111 -> after 1 edge gnt=0001, {s1,s0}=00, valid=1, f=x0.
- REQ-027 Owner 0 drops req while req=4'b1110 -> next edge gnt=0010; owner 1 drops next -> gnt=0100; then owner 2 drops -> gnt=1000, f=x3.
- REQ-028 Only req[2]=1, held for 10 cycles, then dropped (macro undefined) -> gnt=0100 for 10 cycles, then gnt=0000, valid=0, {s1,s0}=10 holds, f=0.
- REQ-029 Macro defined, MAX_BURST=4, req=4'b0011 held -> gnt alternates 0001 and 0010 every 4 cycles.
- REQ-030 Reset asserted mid-grant between clock edges -> gnt, valid, s1, s0 go to 0 before the next edge; x0..x3 randomized each cycle with valid=1 -> f===selected xi every cycle.
